layer0_input_framer: RTL and testbench

LAYER0_INPUT_FRAMER -- requirements
Module: layer0_input_framer

---
 rtl/layer0_pkg.sv | 23 ++
 rtl/layer0_input_framer_if.sv | 36 +++
 rtl/layer0_quantizer.sv | 38 +++
 rtl/layer0_input_framer.sv | 131 +++++++++++++
 tb/tb_layer0_input_framer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/layer0_pkg.sv
// ---------------------------------------------------------------------------
// layer0_pkg
// Shared definitions for the layer0 input framer: default frame geometry,
// the default quantization thresholds and the framer FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package layer0_pkg;

    localparam int N_FEAT_DEF = 16;   // features per frame
    localparam int IN_W_DEF   = 16;   // signed raw sample width
    localparam int Q_W_DEF    = 2;    // code width per feature

    // Ascending signed thresholds, TH[k] at [k*IN_W +: IN_W]:
    // TH[0] = -2048 (lowest bits), TH[1] = 0, TH[2] = +2048.
    localparam logic [(2**Q_W_DEF-1)*IN_W_DEF-1:0] TH_DEF =
        {16'sh0800, 16'sh0000, 16'shF800};

    typedef enum logic {
        ST_COLLECT = 1'b0,   // accepting samples into the assembly slots
        ST_HOLD    = 1'b1    // complete frame parked, waiting for output room
    } state_e;

endpackage

// File: rtl/layer0_input_framer_if.sv
// ---------------------------------------------------------------------------
// layer0_input_framer_if
// Bundles the raw-sample input stream and the quantized-frame output stream
// of the framer.
//   s_valid/s_ready/s_data/s_last : sample stream into the framer
//   m_valid/m_ready/m_data        : frame stream toward layer0 neurons
//   err                           : sticky frame-length error flag
// Modports: slave  - the framer itself
//           master - the environment (sample source + frame sink)
// ---------------------------------------------------------------------------
interface layer0_input_framer_if
    import layer0_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int Q_W    = Q_W_DEF
);
    logic                     s_valid;
    logic                     s_ready;
    logic [IN_W-1:0]          s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [N_FEAT*Q_W-1:0]    m_data;
    logic                     err;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, err
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, err
    );
endinterface

// File: rtl/layer0_quantizer.sv
// ---------------------------------------------------------------------------
// layer0_quantizer
// Combinational threshold quantizer: code = number of thresholds that the
// signed input is greater than or equal to.
//   data_i [IN_W] : signed raw sample
//   code_o [Q_W]  : quantized code, 0 .. 2**Q_W-1
// ---------------------------------------------------------------------------
module layer0_quantizer
    import layer0_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int Q_W  = Q_W_DEF,
    parameter logic [(2**Q_W-1)*IN_W-1:0] TH = TH_DEF
) (
    input  logic [IN_W-1:0] data_i,
    output logic [Q_W-1:0]  code_o
);
    localparam int N_TH = 2**Q_W - 1;

    logic [N_TH-1:0] ge;

    genvar gi;
    generate
        for (gi = 0; gi < N_TH; gi++) begin : g_cmp
            logic signed [IN_W-1:0] th_k;
            assign th_k     = TH[gi*IN_W +: IN_W];
            assign ge[gi]   = $signed(data_i) >= th_k;
        end
    endgenerate

    // Population count of the compare bits; cannot exceed N_TH so it fits Q_W.
    always_comb begin
        code_o = '0;
        for (int k = 0; k < N_TH; k++) begin
            code_o = code_o + Q_W'(ge[k]);
        end
    end
endmodule

// File: rtl/layer0_input_framer.sv
// ---------------------------------------------------------------------------
// layer0_input_framer
// Collects N_FEAT raw samples, quantizes each on the fly and presents the
// packed frame (feature i at [i*Q_W +: Q_W]) to the layer0 register stage.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : layer0_input_framer_if.slave (sample in, frame out, err)
// A completed frame goes straight to the output register when it is empty
// or draining; otherwise it is parked in the assembly slots (HOLD) and the
// input is stalled until the output register frees up.
// ---------------------------------------------------------------------------
module layer0_input_framer
    import layer0_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int Q_W    = Q_W_DEF,
    parameter logic [(2**Q_W-1)*IN_W-1:0] TH = TH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    layer0_input_framer_if.slave  bus
);
    localparam int FW    = N_FEAT * Q_W;
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FW-1:0]      slots_q, slots_d, slots_wr;
    logic [FW-1:0]      out_q, out_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [Q_W-1:0]     code;
    logic               accept, at_end, complete, out_free;

    layer0_quantizer #(
        .IN_W (IN_W),
        .Q_W  (Q_W),
        .TH   (TH)
    ) u_quant (
        .data_i (bus.s_data),
        .code_o (code)
    );

    assign bus.s_ready = (state_q == ST_COLLECT);
    assign accept      = bus.s_valid && bus.s_ready;
    assign at_end      = (idx_q == IDX_W'(N_FEAT - 1));
    assign complete    = accept && (bus.s_last || at_end);
    assign out_free    = !valid_q || bus.m_ready;

    // Assembly slots with the current sample's code merged in at idx.
    genvar gi;
    generate
        for (gi = 0; gi < N_FEAT; gi++) begin : g_slot
            assign slots_wr[gi*Q_W +: Q_W] = (accept && idx_q == IDX_W'(gi))
                                           ? code : slots_q[gi*Q_W +: Q_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;

        // Output drains unless a new frame is loaded below.
        if (valid_q && bus.m_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (complete) begin
                        idx_d = '0;
                        // Early s_last, or no s_last on the final slot.
                        if (bus.s_last != at_end) begin
                            err_d = 1'b1;
                        end
                        if (out_free) begin
                            out_d   = slots_wr;
                            valid_d = 1'b1;
                            slots_d = '0;
                        end else begin
                            slots_d = slots_wr;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        slots_d = slots_wr;
                    end
                end
            end
            ST_HOLD: begin
                // valid_q is 1 here, so m_ready means the output is draining.
                if (bus.m_ready) begin
                    out_d   = slots_q;
                    valid_d = 1'b1;
                    slots_d = '0;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            slots_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slots_q <= slots_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_data  = out_q;
    assign bus.m_valid = valid_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_layer0_input_framer.sv
// ---------------------------------------------------------------------------
// tb_layer0_input_framer
// Directed, table-driven bench for layer0_input_framer. Two sample tables
// (a ramp and a threshold-boundary set) carry hand-computed codes; frames are
// built from them and compared against the packed m_data.
// ---------------------------------------------------------------------------
module tb_layer0_input_framer;
    import layer0_pkg::*;

    localparam int NF = 16;
    localparam int IW = 16;
    localparam int QW = 2;
    localparam int FW = NF * QW;

    typedef struct {
        logic [IW-1:0] data;
        logic [QW-1:0] code;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer0_input_framer_if #(.N_FEAT(NF), .IN_W(IW), .Q_W(QW)) bus ();

    layer0_input_framer #(
        .N_FEAT (NF),
        .IN_W   (IW),
        .Q_W    (QW),
        .TH     (TH_DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    vec_t tab [2][NF];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [FW-1:0] exp_frame(input int t, input int n);
        logic [FW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*QW +: QW] = tab[t][i].code;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Drives n samples of table t back to back; s_last on the n-th if asked.
    // Counts m_valid highs seen before the final edge and cycles spent stalled.
    task automatic run_frame(input int t, input int n, input bit with_last,
                             output int mv_early, output int rdy_low);
        mv_early = 0;
        rdy_low  = 0;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = tab[t][i].data;
            bus.s_last  = with_last && (i == n - 1);
            for (int w = 0; w < 50 && !bus.s_ready; w++) begin
                rdy_low++;
                step();
            end
            if (!bus.s_ready) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: s_ready stuck at 0, expected 1 within 50 cycles");
            end
            step();
            if (i < n - 1 && bus.m_valid) mv_early++;
        end
    endtask

    initial begin
        int ad [NF] = '{-4096, -3584, -3072, -2560, -2048, -1536, -1024, -512,
                        0, 512, 1024, 1536, 2048, 2560, 3072, 3584};
        int ac [NF] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
        int bd [NF] = '{-2049, -2048, -1, 0, 2047, 2048, -32768, 32767,
                        -2047, 2049, 1, -2, 100, -100, -4096, 4096};
        int bc [NF] = '{0, 1, 1, 2, 2, 3, 0, 3, 1, 3, 2, 1, 2, 1, 0, 3};
        int mv, rl, mv2, rl2;

        for (int i = 0; i < NF; i++) begin
            tab[0][i].data = IW'(ad[i]);
            tab[0][i].code = QW'(ac[i]);
            tab[1][i].data = IW'(bd[i]);
            tab[1][i].code = QW'(bc[i]);
        end

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_valid", FW'(bus.m_valid), FW'(0));
        chk("rst err", FW'(bus.err), FW'(0));
        chk("rst m_data", bus.m_data, '0);
        rst_n = 1'b1;
        #1;
        chk("rst s_ready", FW'(bus.s_ready), FW'(1));

        // Ramp frame, output always ready
        bus.m_ready = 1'b1;
        run_frame(0, NF, 1'b1, mv, rl);
        chk("ramp early m_valid", FW'(mv), FW'(0));
        chk("ramp m_valid", FW'(bus.m_valid), FW'(1));
        chk("ramp m_data", bus.m_data, exp_frame(0, NF));
        chk("ramp err", FW'(bus.err), FW'(0));
        idle();
        step();
        chk("ramp drained", FW'(bus.m_valid), FW'(0));

        // Threshold boundary frame
        run_frame(1, NF, 1'b1, mv, rl);
        chk("bound m_valid", FW'(bus.m_valid), FW'(1));
        chk("bound m_data", bus.m_data, exp_frame(1, NF));
        chk("bound err", FW'(bus.err), FW'(0));
        idle();
        step();

        // Backpressure: two frames with m_ready low, second one parks in HOLD
        bus.m_ready = 1'b0;
        run_frame(0, NF, 1'b1, mv, rl);
        chk("bp first m_valid", FW'(bus.m_valid), FW'(1));
        run_frame(1, NF, 1'b1, mv, rl);
        chk("bp hold s_ready", FW'(bus.s_ready), FW'(0));
        chk("bp hold m_data", bus.m_data, exp_frame(0, NF));
        idle();
        step();
        step();
        chk("bp stable m_data", bus.m_data, exp_frame(0, NF));
        chk("bp stable s_ready", FW'(bus.s_ready), FW'(0));
        bus.m_ready = 1'b1;
        step();
        chk("bp release m_data", bus.m_data, exp_frame(1, NF));
        chk("bp release m_valid", FW'(bus.m_valid), FW'(1));
        chk("bp release s_ready", FW'(bus.s_ready), FW'(1));
        step();
        chk("bp release drained", FW'(bus.m_valid), FW'(0));

        // Back-to-back frames at full rate
        run_frame(0, NF, 1'b1, mv, rl);
        chk("b2b frame1 m_data", bus.m_data, exp_frame(0, NF));
        chk("b2b frame1 m_valid", FW'(bus.m_valid), FW'(1));
        run_frame(1, NF, 1'b1, mv2, rl2);
        chk("b2b frame2 m_data", bus.m_data, exp_frame(1, NF));
        chk("b2b frame2 m_valid", FW'(bus.m_valid), FW'(1));
        chk("b2b gap between frames", FW'(mv + mv2), FW'(0));
        chk("b2b s_ready stalls", FW'(rl + rl2), FW'(0));
        idle();
        step();

        // Early s_last on the 5th sample
        run_frame(0, 5, 1'b1, mv, rl);
        chk("short m_valid", FW'(bus.m_valid), FW'(1));
        chk("short m_data", bus.m_data, exp_frame(0, 5));
        chk("short err", FW'(bus.err), FW'(1));
        idle();
        step();
        run_frame(1, NF, 1'b1, mv, rl);
        chk("after short m_data", bus.m_data, exp_frame(1, NF));
        chk("after short err sticky", FW'(bus.err), FW'(1));
        idle();
        step();

        // Reset with a frame held and 7 samples in assembly
        bus.m_ready = 1'b0;
        run_frame(0, NF, 1'b1, mv, rl);
        run_frame(1, 7, 1'b0, mv, rl);
        idle();
        chk("pre-reset held m_valid", FW'(bus.m_valid), FW'(1));
        rst_n = 1'b0;
        #1;
        chk("async rst m_valid", FW'(bus.m_valid), FW'(0));
        chk("async rst err", FW'(bus.err), FW'(0));
        chk("async rst m_data", bus.m_data, '0);
        step();
        step();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        run_frame(0, NF, 1'b1, mv, rl);
        chk("post-rst no stale frame", FW'(mv), FW'(0));
        chk("post-rst m_data", bus.m_data, exp_frame(0, NF));
        chk("post-rst err", FW'(bus.err), FW'(0));
        idle();
        step();
        chk("post-rst single frame", FW'(bus.m_valid), FW'(0));

        // Missing s_last on the 16th sample
        run_frame(0, NF, 1'b0, mv, rl);
        chk("nolast m_valid", FW'(bus.m_valid), FW'(1));
        chk("nolast m_data", bus.m_data, exp_frame(0, NF));
        chk("nolast err", FW'(bus.err), FW'(1));
        run_frame(1, NF, 1'b1, mv, rl);
        chk("nolast next frame m_data", bus.m_data, exp_frame(1, NF));
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
